// File: rtl/dram_cmd_arbiter.sv
// Round-robin DRAM command arbiter with per-bank and global timing counters and a registered command bus.
// Optional macro ARB_READ_FIRST_EN: eligible RD requests win over other command types.
module dram_cmd_arbiter #(
    parameter int NUM_BANKS = 8,
    parameter int ADDR_BITS = 14,
    parameter int TRCD      = 4,
    parameter int TRP       = 4,
    parameter int TRAS      = 10,
    parameter int TRRD      = 2,
    parameter int TCCD      = 2,
    parameter int TWTR      = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           init_done,
    input  logic [NUM_BANKS-1:0]           req,
    input  logic [2*NUM_BANKS-1:0]         req_type,
    input  logic [NUM_BANKS-1:0]           issue,
    input  logic [ADDR_BITS*NUM_BANKS-1:0] issue_addr,
    output logic [NUM_BANKS-1:0]           stall,
    output logic                           cmd_valid,
    output logic [1:0]                     cmd_type,
    output logic [2:0]                     cmd_bank,
    output logic [ADDR_BITS-1:0]           cmd_addr,
    output logic                           proto_err
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = 8;

    localparam logic [1:0] CMD_ACT = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_WR  = 2'd2;
    localparam logic [1:0] CMD_PRE = 2'd3;

    logic [CW-1:0] trcd_cnt [NUM_BANKS];
    logic [CW-1:0] tras_cnt [NUM_BANKS];
    logic [CW-1:0] trp_cnt  [NUM_BANKS];
    logic [CW-1:0] trrd_cnt;
    logic [CW-1:0] tccd_cnt;
    logic [CW-1:0] twtr_cnt;

    logic [BW-1:0]        rr_ptr;
    logic                 pend_valid;
    logic [BW-1:0]        pend_bank;
    logic [1:0]           pend_type;
    logic [NUM_BANKS-1:0] eligible;
    logic [NUM_BANKS-1:0] rd_eligible;
    logic                 grant_valid;
    logic [BW-1:0]        grant_bank;
    logic [1:0]           grant_type;
    logic [BW-1:0]        search_idx;
    logic [NUM_BANKS-1:0] pend_onehot;
    logic [NUM_BANKS-1:0] stray_issue;
    logic                 issue_ok;

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // A bank is eligible only when the timing rule for the type it requests right now is satisfied.
    always_comb begin
        eligible    = '0;
        rd_eligible = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            case (req_type[2*b +: 2])
                CMD_ACT: eligible[b] = (trp_cnt[b] == '0) && (trrd_cnt == '0);
                CMD_RD:  eligible[b] = (trcd_cnt[b] == '0) && (tccd_cnt == '0) && (twtr_cnt == '0);
                CMD_WR:  eligible[b] = (trcd_cnt[b] == '0) && (tccd_cnt == '0);
                default: eligible[b] = (tras_cnt[b] == '0);
            endcase
            eligible[b]    = eligible[b] && rst_n && init_done && req[b] && !pend_valid;
            rd_eligible[b] = eligible[b] && (req_type[2*b +: 2] == CMD_RD);
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_bank  = '0;
        search_idx  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            search_idx = rr_ptr + BW'(i);
            if (!grant_valid && eligible[search_idx]) begin
                grant_valid = 1'b1;
                grant_bank  = search_idx;
            end
        end
`ifdef ARB_READ_FIRST_EN
        if (|rd_eligible) begin
            grant_valid = 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                search_idx = rr_ptr + BW'(i);
                if (!grant_valid && rd_eligible[search_idx]) begin
                    grant_valid = 1'b1;
                    grant_bank  = search_idx;
                end
            end
        end
`endif
        grant_type = req_type[{grant_bank, 1'b0} +: 2];
        stall      = '1;
        if (grant_valid) begin
            stall[grant_bank] = 1'b0;
        end
    end

    // Any issue outside the single pending bank's slot is a handshake violation.
    always_comb begin
        pend_onehot = '0;
        if (pend_valid) begin
            pend_onehot[pend_bank] = 1'b1;
        end
        stray_issue = issue & ~pend_onehot;
        issue_ok    = pend_valid && issue[pend_bank];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                trcd_cnt[b] <= '0;
                tras_cnt[b] <= '0;
                trp_cnt[b]  <= '0;
            end
            trrd_cnt   <= '0;
            tccd_cnt   <= '0;
            twtr_cnt   <= '0;
            rr_ptr     <= '0;
            pend_valid <= 1'b0;
            pend_bank  <= '0;
            pend_type  <= '0;
            cmd_valid  <= 1'b0;
            cmd_type   <= '0;
            cmd_bank   <= '0;
            cmd_addr   <= '0;
            proto_err  <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                trcd_cnt[b] <= sat_dec(trcd_cnt[b]);
                tras_cnt[b] <= sat_dec(tras_cnt[b]);
                trp_cnt[b]  <= sat_dec(trp_cnt[b]);
            end
            trrd_cnt <= sat_dec(trrd_cnt);
            tccd_cnt <= sat_dec(tccd_cnt);
            twtr_cnt <= sat_dec(twtr_cnt);

            // Loads at grant time override the per-cycle decrement.
            pend_valid <= grant_valid;
            if (grant_valid) begin
                rr_ptr    <= grant_bank + 1'b1;
                pend_bank <= grant_bank;
                pend_type <= grant_type;
                case (grant_type)
                    CMD_ACT: begin
                        trcd_cnt[grant_bank] <= CW'(TRCD - 1);
                        tras_cnt[grant_bank] <= CW'(TRAS - 1);
                        trrd_cnt             <= CW'(TRRD - 1);
                    end
                    CMD_PRE: trp_cnt[grant_bank] <= CW'(TRP - 1);
                    CMD_RD:  tccd_cnt <= CW'(TCCD - 1);
                    default: begin
                        tccd_cnt <= CW'(TCCD - 1);
                        twtr_cnt <= CW'(TWTR - 1);
                    end
                endcase
            end

            cmd_valid <= issue_ok;
            if (issue_ok) begin
                cmd_type <= pend_type;
                cmd_bank <= 3'(pend_bank);
                cmd_addr <= issue_addr[pend_bank*ADDR_BITS +: ADDR_BITS];
            end

            if ((|stray_issue) || (pend_valid && !issue[pend_bank])) begin
                proto_err <= 1'b1;
            end
        end
    end
endmodule
